flag_fwd_unit: RTL
==================

Name: flag_fwd_unit

Overview:
- Condition-flag register that sits directly upstream of the branch condition evaluator.
- Captures N/V/Z from the ALU on flag-setting instructions and forwards the same-cycle ALU result combinationally to the evaluator.
- Tracks flag-setting instructions still in flight so the decode stage stalls a conditional branch until its flags are final.

Parameters:
- MAX_PEND, 3: maximum flag-setting instructions in flight between issue and ALU writeback.
- CNT_W, 2: pending-counter width; must satisfy 2^CNT_W > MAX_PEND.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_flag  in  1  a flag-setting instruction enters EX this cycle.
- alu_valid  in  1  ALU presents a flag result this cycle.
- set_zn  in  1  with alu_valid: update Z and N.
- set_v  in  1  with alu_valid: update V.
- alu_N  in  1  ALU negative result.
- alu_V  in  1  ALU overflow result.
- alu_Z  in  1  ALU zero result.
- flush  in  1  squash all in-flight flag-setting instructions.
- N  out  1  forwarded negative flag to the branch evaluator.
- V  out  1  forwarded overflow flag.
- Z  out  1  forwarded zero flag.
- flags_busy  out  1  flags not yet final; decode must hold a conditional branch.
- pend_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n=0): N_q=V_q=Z_q=0, cnt=0, pend_err=0, state=IDLE. Outputs therefore show N=V=Z=0, flags_busy=0, pend_err=0.
- Flag registers, on the clock edge:
  - alu_valid & set_zn: N_q<=alu_N, Z_q<=alu_Z.
  - alu_valid & set_v: V_q<=alu_V.
  - Otherwise the flags hold.
  - alu_valid with neither set bit: no flag change, but still counts as a retire.
- Forwarding (combinational, zero latency):
  - N = (alu_valid & set_zn) ? alu_N : N_q.
  - Z uses the same rule as N.
  - V = (alu_valid & set_v) ? alu_V : V_q.
- Pending counter cnt, next-state priority:
  - flush: cnt<=0. Same-cycle issue and alu_valid are ignored for counting; alu_valid still writes the flags.
  - issue_flag & alu_valid: cnt unchanged.
  - issue_flag only: cnt<=cnt+1. If cnt==MAX_PEND, cnt holds and pend_err<=1.
  - alu_valid only: cnt<=cnt-1. If cnt==0, cnt stays 0 (no wrap), pend_err<=1, and the flags still update.
- flags_busy = (cnt>1) | (cnt==1 & ~alu_valid).
  - The retiring instruction's result is forwarded, so flags_busy drops in the same cycle the last result arrives.
  - Same-cycle issue_flag does not raise flags_busy; it takes effect next cycle.
- State machine, for visibility and assertions:
  - IDLE (cnt==0) -> PEND on issue without retire.
  - PEND -> IDLE when cnt reaches 0, either by retire or by flush.
  - State is a pure function of cnt; a mismatch is an assertion failure.
- pend_err is sticky until reset and has no other effect on function.
- Reset asserted mid-operation: all state clears immediately, with no dependence on the clock.

Decomposition:
- Shared package:
  - flag bit-index constants: N=2, V=1, Z=0.
  - state encoding: IDLE=1'b0, PEND=1'b1.
  - default MAX_PEND.
- Shared with the branch evaluator's condition encoding (NEQ..UN).
- One natural sub-module: flag_pend_cnt, the saturating up/down counter with error detection. Flag registers and forwarding muxes stay in the top.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, release -> N=V=Z=0, flags_busy=0, pend_err=0, outputs stable for 5 cycles.
- Forwarding:
  - Setup: issue_flag=1 at cycle 0.
  - Cycle 1: flags_busy=1.
  - Cycle 2, stimulus: alu_valid=1, set_zn=1, set_v=1, alu_N=1, alu_V=0, alu_Z=0.
  - Cycle 2, response: N=1 combinationally, flags_busy=0.
  - Cycle 3: N_q=1, cnt=0.
- Partial update: flags N=1,V=1,Z=0, then alu_valid with set_zn=1, set_v=0, alu_N=0, alu_Z=1, alu_V=0 -> N=0, Z=1, V stays 1.
- Back-to-back pipeline:
  - Stimulus: issue on cycles 0,1,2; alu_valid on cycles 2,3,4; issue and retire coincide at cycle 2.
  - Response: cnt sequence 1,2,2,1,0; flags_busy=1 through cycle 3, 0 at cycle 4.
- Flush: cnt=3, then flush=1 with issue_flag=1 -> next cycle cnt=0, flags_busy=0, state=IDLE.
- Errors:
  - 4 issues with no retire -> cnt saturates at 3, pend_err=1.
  - After reset, alu_valid at cnt=0 with alu_Z=1, set_zn=1 -> Z=1, cnt=0, pend_err=1.

Source files
------------

// File: rtl/flag_fwd_unit_pkg.sv
// Shared definitions for the condition-flag path: flag bit positions,
// pending-tracker state encoding and the branch condition encoding.
package flag_fwd_unit_pkg;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  localparam int MAX_PEND_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // Condition codes understood by the downstream branch evaluator.
  typedef enum logic [2:0] {
    NEQ = 3'd0,
    EQ  = 3'd1,
    LT  = 3'd2,
    GE  = 3'd3,
    GT  = 3'd4,
    LE  = 3'd5,
    OV  = 3'd6,
    UN  = 3'd7
  } cond_t;

endpackage

// File: rtl/flag_pend_cnt.sv
// Saturating up/down count of flag-setting instructions in flight, with a
// sticky error on overflow (issue at MAX_PEND) or underflow (retire at 0).
module flag_pend_cnt #(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic             retire,
  input  logic             flush,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic             err
);

  logic err_set;

  // Flush dominates; a simultaneous issue and retire cancel out.
  always_comb begin
    cnt_next = cnt;
    err_set  = 1'b0;
    if (flush) begin
      cnt_next = '0;
    end else if (issue && !retire) begin
      if (cnt == CNT_W'(MAX_PEND)) err_set  = 1'b1;
      else                         cnt_next = cnt + CNT_W'(1);
    end else if (retire && !issue) begin
      if (cnt == '0) err_set  = 1'b1;
      else           cnt_next = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_next;
      err <= err | err_set;
    end
  end

endmodule

// File: rtl/flag_fwd_unit.sv
// N/V/Z flag register with same-cycle ALU forwarding and an in-flight
// tracker that tells decode when the flags are not yet final.
module flag_fwd_unit
  import flag_fwd_unit_pkg::*;
#(
  parameter int MAX_PEND = MAX_PEND_DEF,
  parameter int CNT_W    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue_flag,
  input  logic alu_valid,
  input  logic set_zn,
  input  logic set_v,
  input  logic alu_N,
  input  logic alu_V,
  input  logic alu_Z,
  input  logic flush,
  output logic N,
  output logic V,
  output logic Z,
  output logic flags_busy,
  output logic pend_err
);

  logic [2:0]       flags_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  state_t           state;
  state_t           state_next;
  logic             upd_zn;
  logic             upd_v;

  assign upd_zn = alu_valid & set_zn;
  assign upd_v  = alu_valid & set_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else begin
      if (upd_zn) begin
        flags_q[FLAG_N] <= alu_N;
        flags_q[FLAG_Z] <= alu_Z;
      end
      if (upd_v) flags_q[FLAG_V] <= alu_V;
    end
  end

  // Forward the retiring result so the evaluator never sees stale flags.
  assign N = upd_zn ? alu_N : flags_q[FLAG_N];
  assign Z = upd_zn ? alu_Z : flags_q[FLAG_Z];
  assign V = upd_v  ? alu_V : flags_q[FLAG_V];

  flag_pend_cnt #(
    .MAX_PEND (MAX_PEND),
    .CNT_W    (CNT_W)
  ) u_pend_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (issue_flag),
    .retire   (alu_valid),
    .flush    (flush),
    .cnt      (cnt),
    .cnt_next (cnt_next),
    .err      (pend_err)
  );

  assign flags_busy = (cnt > CNT_W'(1)) | ((cnt == CNT_W'(1)) & ~alu_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cnt_next != '0) state_next = PEND;
      PEND:    if (cnt_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifndef SYNTHESIS
  state_matches_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    state == ((cnt != '0) ? PEND : IDLE));
`endif

endmodule
